// File: rtl/key_rec_pkg.sv
// key_rec_pkg: shared constants, FSM states and event-entry packing for the key recorder.
package key_rec_pkg;
    localparam int KEYS    = 12;
    localparam int DUR_W   = 16;
    localparam int ENTRY_W = KEYS + DUR_W;

    typedef enum logic [1:0] {IDLE, RECORD, PLAY_LOAD, PLAY_HOLD} state_e;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [KEYS-1:0] k, input logic [DUR_W-1:0] d);
        return {k, d};
    endfunction

    function automatic logic [KEYS-1:0] entry_keys(input logic [ENTRY_W-1:0] e);
        return e[ENTRY_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] e);
        return e[DUR_W-1:0];
    endfunction
endpackage

// File: rtl/key_recorder_player_if.sv
// key_recorder_player_if: key lines, control pulses and status between a host and the recorder.
interface key_recorder_player_if #(parameter int CNT_W = 7);
    import key_rec_pkg::*;
    logic [KEYS-1:0]  keys_in;
    logic [KEYS-1:0]  keys_out;
    logic             rec;
    logic             play;
    logic             busy;
    logic             full;
    logic [CNT_W-1:0] event_count;
    modport master (output keys_in, rec, play, input keys_out, busy, full, event_count);
    modport slave (input keys_in, rec, play, output keys_out, busy, full, event_count);
endinterface

// File: rtl/key_event_ram.sv
// key_event_ram: single-port event store with synchronous write and registered read.
module key_event_ram
    import key_rec_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [ENTRY_W-1:0]       wdata_i,
    output logic [ENTRY_W-1:0]       rdata_o
);
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/key_recorder_player.sv
// key_recorder_player: passes synchronized keys to the tone generator, records
// key-vector changes with tick durations and replays them with the original timing.
module key_recorder_player
    import key_rec_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int TICK_DIV = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    key_recorder_player_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0]    TMAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]    CMAX = CW'(DEPTH);
    localparam logic [DUR_W-1:0] DMAX = '1;

    state_e             state_q, state_d;
    logic [KEYS-1:0]    s1_q, ks_q, cur_q, cur_d, out_q, out_d, rd_keys;
    logic [DUR_W-1:0]   dur_q, dur_d, dur_inc, pcnt_q, pcnt_d, rd_dur;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc, addr_q, addr_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               full_q, full_d, tick, we, last, hold_done;
    logic [ENTRY_W-1:0] wdata, rdata;
    logic [AW-1:0]      ram_addr;

    key_event_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .addr_i  (ram_addr),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    assign tick      = presc_q == TMAX;
    assign dur_inc   = dur_q + 1'b1;
    assign cnt_inc   = cnt_q + 1'b1;
    assign rd_keys   = entry_keys(rdata);
    assign rd_dur    = entry_dur(rdata);
    assign last      = addr_q + 1'b1 == cnt_q;
    assign hold_done = tick && pcnt_q + 1'b1 == rd_dur;
    assign ram_addr  = state_q == RECORD ? cnt_q[AW-1:0] : addr_q[AW-1:0];
    assign presc_d   = (tick || state_d != state_q) ? '0 : presc_q + 1'b1;

    // During hold the entry keys come straight from the registered RAM read.
    assign bus.keys_out    = state_q == PLAY_HOLD ? rd_keys : out_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.full        = full_q;
    assign bus.event_count = cnt_q;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dur_d   = dur_q;
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        full_d  = full_q;
        out_d   = out_q;
        we      = 1'b0;
        wdata   = pack_entry(cur_q, dur_inc);
        unique case (state_q)
            IDLE: begin
                out_d = ks_q;
                if (bus.rec) begin
                    state_d = RECORD;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                    cur_d   = ks_q;
                    dur_d   = '0;
                end else if (bus.play && cnt_q != '0) begin
                    state_d = PLAY_LOAD;
                    addr_d  = '0;
                end
            end
            RECORD: begin
                out_d = ks_q;
                if (bus.rec) begin
                    we      = dur_q != '0;
                    wdata   = pack_entry(cur_q, dur_q);
                    state_d = IDLE;
                end else if (tick) begin
                    we      = ks_q != cur_q || dur_inc == DMAX;
                    cur_d   = ks_q;
                    dur_d   = we ? '0 : dur_inc;
                    state_d = we && cnt_inc == CMAX ? IDLE : RECORD;
                end
                cnt_d  = we ? cnt_inc : cnt_q;
                full_d = we && cnt_inc == CMAX;
            end
            PLAY_LOAD: begin
                state_d = bus.play ? IDLE : PLAY_HOLD;
                out_d   = bus.play ? '0 : out_q;
                pcnt_d  = '0;
            end
            PLAY_HOLD: begin
                out_d  = rd_keys;
                pcnt_d = tick ? pcnt_q + 1'b1 : pcnt_q;
                if (bus.play) begin
                    state_d = IDLE;
                    out_d   = '0;
                end else if (hold_done) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = last ? IDLE : PLAY_LOAD;
                    out_d   = last ? '0 : rd_keys;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            ks_q    <= '0;
            state_q <= IDLE;
            cur_q   <= '0;
            dur_q   <= '0;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            full_q  <= 1'b0;
            out_q   <= '0;
            presc_q <= '0;
        end else begin
            s1_q    <= bus.keys_in;
            ks_q    <= s1_q;
            state_q <= state_d;
            cur_q   <= cur_d;
            dur_q   <= dur_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            full_q  <= full_d;
            out_q   <= out_d;
            presc_q <= presc_d;
        end
    end
endmodule
